serial_word_tx: RTL and testbench

SERIAL_WORD_TX -- requirements
Module: serial_word_tx

---
 rtl/serial_word_tx_pkg.sv | 17 +
 rtl/serial_word_tx_if.sv | 27 ++
 rtl/serial_word_tx_baud_tick_counter.sv | 30 +++
 rtl/serial_word_tx.sv | 106 ++++++++++
 tb/tb_serial_word_tx.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/serial_word_tx_pkg.sv
// rtl/serial_word_tx_pkg.sv - shared types and constants for the serial word transmitter
// Purpose: frame state enumeration, data width and serial idle level.
// Ports: none (package).
package serial_tx_pkg;

    localparam int   DATA_W     = 4;
    localparam logic IDLE_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

endpackage

// File: rtl/serial_word_tx_if.sv
// rtl/serial_word_tx_if.sv - word handshake and serial line bundle
// Purpose: groups the upstream word handshake with the serial/status outputs.
// Signals: in_valid/in_ready/in_data/msb_first (word handshake),
//          serial_out, busy, done (line and frame status).
// Modports: master = upstream word source and line observer, slave = transmitter.
interface serial_word_tx_if;
    import serial_tx_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              msb_first;
    logic              serial_out;
    logic              busy;
    logic              done;

    modport master (
        output in_valid, in_data, msb_first,
        input  in_ready, serial_out, busy, done
    );

    modport slave (
        input  in_valid, in_data, msb_first,
        output in_ready, serial_out, busy, done
    );

endinterface

// File: rtl/serial_word_tx_baud_tick_counter.sv
// rtl/serial_word_tx_baud_tick_counter.sv - bit-period counter
// Purpose: counts 0..CLKS_PER_BIT-1 and wraps; o_tick marks the last cycle of a bit.
// Ports: clk, rst (sync active-high), i_clear (hold count at 0), o_tick (last count).
module baud_tick_counter #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    output logic o_tick
);

    localparam logic [7:0] LAST = 8'(CLKS_PER_BIT - 1);

    logic [7:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_count <= 8'd0;
        end else if (r_count == LAST) begin
            r_count <= 8'd0;
        end else begin
            r_count <= r_count + 8'd1;
        end
    end

    // Held at zero while cleared, so no tick can leak out of IDLE.
    assign o_tick = !i_clear && (r_count == LAST);

endmodule

// File: rtl/serial_word_tx.sv
// rtl/serial_word_tx.sv - 4-bit word to framed serial line transmitter
// Purpose: accepts a word on a valid/ready handshake and sends
//          start(0), 4 data bits, optional even parity, stop(1).
// Ports: clk, rst (sync active-high), bus (serial_word_tx_if.slave).
module serial_word_tx
    import serial_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 1
) (
    input  logic               clk,
    input  logic               rst,
    serial_word_tx_if.slave    bus
);

    state_t            r_state;
    state_t            w_next;
    logic [DATA_W-1:0] r_shift;
    logic              r_msb;
    logic              r_parity;
    logic [1:0]        r_bit_idx;
    logic              w_tick;
    logic              w_idle;
    logic              w_accept;
    logic              w_data_bit;

    assign w_idle   = (r_state == ST_IDLE);
    assign w_accept = w_idle && bus.in_valid;

    // Counter sits at zero in IDLE so the first START cycle is count 0.
    baud_tick_counter #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_idle),
        .o_tick  (w_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (bus.in_valid) w_next = ST_START;
            ST_START:  if (w_tick) w_next = ST_DATA;
            ST_DATA:   if (w_tick && (r_bit_idx == 2'd3))
                           w_next = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
            ST_PARITY: if (w_tick) w_next = ST_STOP;
            ST_STOP:   if (w_tick) w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    // Word is latched on the handshake; the outgoing bit always sits at the
    // end of the register that matches the latched order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift   <= '0;
            r_msb     <= 1'b0;
            r_parity  <= 1'b0;
            r_bit_idx <= 2'd0;
        end else if (w_accept) begin
            r_shift   <= bus.in_data;
            r_msb     <= bus.msb_first;
            r_parity  <= ^bus.in_data;
            r_bit_idx <= 2'd0;
        end else if ((r_state == ST_DATA) && w_tick) begin
            r_shift   <= r_msb ? {r_shift[DATA_W-2:0], 1'b0} : {1'b0, r_shift[DATA_W-1:1]};
            r_bit_idx <= r_bit_idx + 2'd1;
        end
    end

    assign w_data_bit = r_msb ? r_shift[DATA_W-1] : r_shift[0];

    always_comb begin
        bus.serial_out = IDLE_LEVEL;
        bus.in_ready   = 1'b0;
        bus.busy       = 1'b1;
        bus.done       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                bus.in_ready = 1'b1;
                bus.busy     = 1'b0;
            end
            ST_START:  bus.serial_out = 1'b0;
            ST_DATA:   bus.serial_out = w_data_bit;
            ST_PARITY: bus.serial_out = r_parity;
            ST_STOP: begin
                bus.serial_out = 1'b1;
                bus.done       = w_tick;
            end
            default: begin
                bus.in_ready = 1'b1;
                bus.busy     = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_serial_word_tx.sv
// tb/tb_serial_word_tx.sv - self-checking bench for serial_word_tx
module tb_serial_word_tx;

    logic       clk = 1'b0;
    logic [2:0] rst = 3'b111;
    logic [2:0] tb_valid = 3'b000;
    logic [2:0] tb_msb = 3'b000;
    logic [3:0] tb_data [3];
    logic [2:0] so, rdy, bsy, dn;
    logic       chk_en = 1'b0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    function automatic int cpb_of(input int g);
        return (g == 2) ? 1 : 4;
    endfunction

    function automatic int pen_of(input int g);
        return (g == 1) ? 0 : 1;
    endfunction

    function automatic int frame_len(input int g);
        return (6 + pen_of(g)) * cpb_of(g);
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        serial_word_tx_if u_if ();
        assign u_if.in_valid  = tb_valid[g];
        assign u_if.in_data   = tb_data[g];
        assign u_if.msb_first = tb_msb[g];
        assign so[g]  = u_if.serial_out;
        assign rdy[g] = u_if.in_ready;
        assign bsy[g] = u_if.busy;
        assign dn[g]  = u_if.done;

        serial_word_tx #(
            .CLKS_PER_BIT ((g == 2) ? 1 : 4),
            .PARITY_EN    ((g == 1) ? 0 : 1)
        ) u_dut (
            .clk (clk),
            .rst (rst[g]),
            .bus (u_if.slave)
        );
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Frame model: a frame is a list of line levels, each lasting cpb cycles.
    bit       m_act [3] = '{0, 0, 0};
    int       m_k   [3] = '{0, 0, 0};
    logic [3:0] m_word [3];
    bit       m_msb [3] = '{0, 0, 0};

    function automatic logic exp_bit(input int g);
        int b = (m_k[g] - 1) / cpb_of(g);
        if (b == 0) return 1'b0;
        if (b <= 4) return m_msb[g] ? m_word[g][4 - b] : m_word[g][b - 1];
        if (b == 5 && pen_of(g) == 1) return ^m_word[g];
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        for (int g = 0; g < 3; g++) begin
            if (rst[g]) begin
                m_act[g] = 0;
            end else if (m_act[g]) begin
                if (m_k[g] == frame_len(g)) m_act[g] = 0;
                else m_k[g] = m_k[g] + 1;
            end else if (tb_valid[g]) begin
                m_act[g]  = 1;
                m_k[g]    = 1;
                m_word[g] = tb_data[g];
                m_msb[g]  = tb_msb[g];
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int g = 0; g < 3; g++) begin
                chk($sformatf("u%0d_serial_out", g), so[g], m_act[g] ? exp_bit(g) : 1'b1);
                chk($sformatf("u%0d_in_ready", g), rdy[g], !m_act[g]);
                chk($sformatf("u%0d_busy", g), bsy[g], m_act[g]);
                chk($sformatf("u%0d_done", g), dn[g], m_act[g] && (m_k[g] == frame_len(g)));
            end
        end
    end

    // Send one word and pin the line mid-bit against a literal bit list
    // (exp written first bit leftmost, nb bits wide).
    task automatic send_and_pin(input int g, input logic [3:0] w, input logic m,
                                input logic [6:0] exp, input int nb, input int cpb);
        @(negedge clk);
        tb_valid[g] = 1'b1;
        tb_data[g]  = w;
        tb_msb[g]   = m;
        @(negedge clk);
        tb_valid[g] = 1'b0;
        for (int c = 1; c <= nb * cpb; c++) begin
            if (c > 1) @(negedge clk);
            if (((c - 1) % cpb) == (cpb / 2))
                chk($sformatf("pin_u%0d_bit%0d", g, (c - 1) / cpb), so[g], exp[nb - 1 - (c - 1) / cpb]);
            if (c == nb * cpb - 1) chk($sformatf("pin_u%0d_done_early", g), dn[g], 1'b0);
            if (c == nb * cpb)     chk($sformatf("pin_u%0d_done_last", g), dn[g], 1'b1);
        end
    endtask

    initial begin
        logic [14:0] seq;
        int          ready_cnt;
        for (int g = 0; g < 3; g++) tb_data[g] = 4'b0000;

        // Reset, with a word offered while reset is held.
        @(negedge clk);
        chk_en = 1'b1;
        chk("rst_serial_out", so[0], 1'b1);
        chk("rst_in_ready", rdy[0], 1'b1);
        chk("rst_busy", bsy[0], 1'b0);
        chk("rst_done", dn[0], 1'b0);
        tb_valid[0] = 1'b1;
        tb_data[0]  = 4'b1111;
        @(negedge clk);
        chk("rst_priority_ready", rdy[0], 1'b1);
        tb_valid[0] = 1'b0;
        rst = 3'b000;

        send_and_pin(0, 4'b1011, 1'b0, 7'b0110111, 7, 4);
        send_and_pin(0, 4'b1011, 1'b1, 7'b0101111, 7, 4);

        // Word offered mid-frame must be ignored.
        fork
            send_and_pin(0, 4'b1011, 1'b0, 7'b0110111, 7, 4);
            begin
                repeat (6) @(negedge clk);
                tb_valid[0] = 1'b1;
                tb_data[0]  = 4'b0110;
                @(negedge clk);
                tb_valid[0] = 1'b0;
                tb_data[0]  = 4'b1011;
            end
        join
        repeat (3) @(negedge clk);

        // Reset in cycle 10 of a frame.
        tb_data[0]  = 4'b1011;
        tb_msb[0]   = 1'b0;
        tb_valid[0] = 1'b1;
        @(negedge clk);
        tb_valid[0] = 1'b0;
        repeat (9) @(negedge clk);
        rst[0] = 1'b1;
        @(negedge clk);
        chk("abort_serial_out", so[0], 1'b1);
        chk("abort_in_ready", rdy[0], 1'b1);
        chk("abort_busy", bsy[0], 1'b0);
        chk("abort_done", dn[0], 1'b0);
        rst[0] = 1'b0;
        send_and_pin(0, 4'b0100, 1'b0, 7'b0001011, 7, 4);

        // No parity, all-zero word.
        send_and_pin(1, 4'b0000, 1'b0, 7'b0000001, 6, 4);

        // One clock per bit, in_valid held across two words.
        @(negedge clk);
        tb_data[2]  = 4'b1011;
        tb_msb[2]   = 1'b0;
        tb_valid[2] = 1'b1;
        seq = '0;
        ready_cnt = 0;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            if (c == 7) tb_data[2] = 4'b0110;
            if (c == 9) tb_valid[2] = 1'b0;
            seq[15 - c] = so[2];
            ready_cnt = ready_cnt + int'(rdy[2]);
        end
        chk("b2b_sequence", seq, 15'b011011110011001);
        chk("b2b_ready_pulses", ready_cnt, 1);

        repeat (4) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
